// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use interlock, data-memory wait
// freeze with timeout, and branch squash. Also keeps saturating event counters.
module hazard_control_unit #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [4:0]       rs1_D,
   input  logic [4:0]       rs2_D,
   input  logic             use_rs1_D,
   input  logic             use_rs2_D,
   input  logic [4:0]       rd_E,
   input  logic             memRead_E,
   input  logic             branchTaken_E,
   input  logic             dmem_req_M,
   input  logic             dmem_ack_M,
   output logic             stall_F,
   output logic             stall_D,
   output logic             stall_E,
   output logic             stall_M,
   output logic             flush_D,
   output logic             flush_E,
   output logic             flush_W,
   output logic             mem_err,
   output logic [CNT_W-1:0] load_use_cnt,
   output logic [CNT_W-1:0] branch_flush_cnt,
   output logic [CNT_W-1:0] mem_wait_cnt
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

   state_t             r_state;
   logic [TW-1:0]      r_tmo;
   logic               r_memErr;
   logic [CNT_W-1:0]   r_luCnt;
   logic [CNT_W-1:0]   r_brCnt;
   logic [CNT_W-1:0]   r_mwCnt;

   logic w_lu;
   logic w_mw;
   logic w_br;
   logic w_freeze;
   logic w_brAct;
   logic w_luAct;
   logic w_mwCount;

   assign w_lu = memRead_E && (rd_E != 5'd0) &&
                 ((use_rs1_D && (rd_E == rs1_D)) || (use_rs2_D && (rd_E == rs2_D)));
   assign w_mw = dmem_req_M && !dmem_ack_M;
   assign w_br = branchTaken_E;

   // Freeze outranks everything; a branch squashes any dependent instruction, so lu is last.
   assign w_freeze  = (r_state == ERR) || w_mw;
   assign w_brAct   = !w_freeze && w_br;
   assign w_luAct   = !w_freeze && !w_br && w_lu;
   assign w_mwCount = w_mw && (r_state != ERR);

   always_comb begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      stall_E = 1'b0;
      stall_M = 1'b0;
      flush_D = 1'b0;
      flush_E = 1'b0;
      flush_W = 1'b0;
      if (!RST_N) begin
         flush_D = 1'b1;
         flush_E = 1'b1;
         flush_W = 1'b1;
      end else if (w_freeze) begin
         stall_F = 1'b1;
         stall_D = 1'b1;
         stall_E = 1'b1;
         stall_M = 1'b1;
         flush_W = 1'b1;
      end else if (w_brAct) begin
         flush_D = 1'b1;
         flush_E = 1'b1;
      end else if (w_luAct) begin
         stall_F = 1'b1;
         stall_D = 1'b1;
         flush_E = 1'b1;
      end
   end

   // Timeout FSM; mem_err is set on the edge that enters ERR and held until reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state  <= RUN;
         r_tmo    <= '0;
         r_memErr <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_mw) begin
                  r_state <= MEM_WAIT;
                  r_tmo   <= TW'(1);
               end
            end
            MEM_WAIT: begin
               if (!w_mw) begin
                  r_state <= RUN;
               end else if (r_tmo == TW'(MEM_TIMEOUT)) begin
                  r_state  <= ERR;
                  r_memErr <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
            end
            ERR:     r_state <= ERR;
            default: r_state <= RUN;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_luCnt <= '0;
         r_brCnt <= '0;
         r_mwCnt <= '0;
      end else begin
         if (w_luAct && (r_luCnt != '1))   r_luCnt <= r_luCnt + CNT_W'(1);
         if (w_brAct && (r_brCnt != '1))   r_brCnt <= r_brCnt + CNT_W'(1);
         if (w_mwCount && (r_mwCnt != '1)) r_mwCnt <= r_mwCnt + CNT_W'(1);
      end
   end

   assign mem_err          = r_memErr;
   assign load_use_cnt     = r_luCnt;
   assign branch_flush_cnt = r_brCnt;
   assign mem_wait_cnt     = r_mwCnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: a cycle-level reference model pushes expected
// outputs into a queue, and a negedge monitor pops and compares them.
module tb_hazard_control_unit;

   localparam int TMO   = 4;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic [4:0]    rs1_D, rs2_D, rd_E;
   logic          use_rs1_D, use_rs2_D, memRead_E, branchTaken_E, dmem_req_M, dmem_ack_M;
   logic          stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, mem_err;
   logic [CW-1:0] load_use_cnt, branch_flush_cnt, mem_wait_cnt;

   hazard_control_unit #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
      .rd_E(rd_E), .memRead_E(memRead_E), .branchTaken_E(branchTaken_E),
      .dmem_req_M(dmem_req_M), .dmem_ack_M(dmem_ack_M),
      .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
      .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W), .mem_err(mem_err),
      .load_use_cnt(load_use_cnt), .branch_flush_cnt(branch_flush_cnt),
      .mem_wait_cnt(mem_wait_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [6:0] ctl;
      logic       err;
      int         lu;
      int         br;
      int         mw;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   fails  = 0;

   // Reference model state: how long memory has been stalling, whether we timed out, event totals.
   bit   mErrored = 0;
   bit   mWaiting = 0;
   int   mWaitLen = 0;
   int   mLuCnt = 0, mBrCnt = 0, mMwCnt = 0;

   function automatic int sat(input int v);
      return (v < CMAX) ? v + 1 : v;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit rst, input int r1, input int r2, input bit u1,
                                input bit u2, input int rd, input bit mr, input bit bt,
                                input bit req, input bit ack);
      exp_t e;
      bit   lu, mw;
      @(posedge CLK);
      #1;
      RST_N = rst; rs1_D = 5'(r1); rs2_D = 5'(r2); use_rs1_D = u1; use_rs2_D = u2;
      rd_E = 5'(rd); memRead_E = mr; branchTaken_E = bt; dmem_req_M = req; dmem_ack_M = ack;
      e.err = mErrored; e.lu = mLuCnt; e.br = mBrCnt; e.mw = mMwCnt;
      if (!rst) begin
         e.ctl = 7'b0000_111;
         expQ.push_back(e);
         mErrored = 0; mWaiting = 0; mWaitLen = 0; mLuCnt = 0; mBrCnt = 0; mMwCnt = 0;
         return;
      end
      lu = mr && (rd != 0) && ((u1 && rd == r1) || (u2 && rd == r2));
      mw = req && !ack;
      if (mErrored || mw) e.ctl = 7'b1111_001;
      else if (bt)        e.ctl = 7'b0000_110;
      else if (lu)        e.ctl = 7'b1100_010;
      else                e.ctl = 7'b0000_000;
      expQ.push_back(e);
      if (mErrored) begin
      end else if (mw) begin
         mMwCnt = sat(mMwCnt);
         if (!mWaiting) begin
            mWaiting = 1; mWaitLen = 1;
         end else if (mWaitLen == TMO) begin
            mErrored = 1; mWaiting = 0;
         end else begin
            mWaitLen++;
         end
      end else begin
         mWaiting = 0;
         if (bt)      mBrCnt = sat(mBrCnt);
         else if (lu) mLuCnt = sat(mLuCnt);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("ctl", {9'd0, stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W},
                        {9'd0, e.ctl});
            checkOutput("mem_err", {15'd0, mem_err}, {15'd0, e.err});
            checkOutput("load_use_cnt", {12'd0, load_use_cnt}, 16'(e.lu));
            checkOutput("branch_flush_cnt", {12'd0, branch_flush_cnt}, 16'(e.br));
            checkOutput("mem_wait_cnt", {12'd0, mem_wait_cnt}, 16'(e.mw));
         end
      end
   end

   initial begin : driver
      int reqLeft = 0;
      bit req;
      RST_N = 1'b0; rs1_D = '0; rs2_D = '0; use_rs1_D = 0; use_rs2_D = 0; rd_E = '0;
      memRead_E = 0; branchTaken_E = 0; dmem_req_M = 0; dmem_ack_M = 0;
      @(posedge CLK);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // load-use hit, then the same with rd_E = x0
      applyStimulus(1, 5, 0, 1, 0, 5, 1, 0, 0, 0);
      idle(1);
      applyStimulus(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      idle(1);
      // branch coincident with load-use
      applyStimulus(1, 5, 7, 1, 1, 7, 1, 1, 0, 0);
      idle(1);
      // memory wait of 3 cycles with a branch held throughout
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
      idle(2);
      // saturation of the branch counter
      for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      // timeout into ERR, freeze persists through ack and branch
      for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 3, 0, 1, 0, 3, 1, 1, 1, 1);
      // reset while in ERR
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      idle(2);
      // randomized traffic with memory-request bursts
      for (int n = 0; n < 1500; n++) begin
         if (reqLeft > 0) begin
            req = 1; reqLeft--;
         end else begin
            req = 0;
            if ($urandom_range(7) == 0) reqLeft = $urandom_range(10, 1);
         end
         applyStimulus($urandom_range(63) != 0, $urandom_range(3), $urandom_range(3),
                       1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(3),
                       1'($urandom_range(1)), $urandom_range(3) == 0, req,
                       req ? ($urandom_range(3) == 0) : 1'($urandom_range(1)));
      end
      for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge CLK);
      @(posedge CLK);
      if (expQ.size() != 0) checkOutput("drain", 16'(expQ.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Stall/flush controller for the 5-stage pipeline; it handles the hazards that forwarding cannot resolve.
- Detects load-use hazards between Decode and Execute, freezes the pipeline while the data memory withholds its acknowledge, and squashes wrong-path instructions on a taken branch/jump.
- Keeps saturating event counters, a memory-timeout FSM and a sticky error flag.
- Sits beside the forwarding logic and drives the enable/clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- MEM_TIMEOUT, 64, cycles in MEM_WAIT before entering ERR (min 1).
- CNT_W, 16, width of each saturating event counter.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  synchronous active-low reset
- rs1_D  in  5  Decode rs1 address
- rs2_D  in  5  Decode rs2 address
- use_rs1_D  in  1  Decode instruction reads rs1
- use_rs2_D  in  1  Decode instruction reads rs2
- rd_E  in  5  Execute destination register
- memRead_E  in  1  Execute instruction is a load
- branchTaken_E  in  1  Execute redirects PC (taken branch or jump)
- dmem_req_M  in  1  Memory-stage access in progress
- dmem_ack_M  in  1  data memory acknowledge
- stall_F  out  1  hold PC
- stall_D  out  1  hold IF/ID
- stall_E  out  1  hold ID/EX
- stall_M  out  1  hold EX/MEM
- flush_D  out  1  clear IF/ID to NOP
- flush_E  out  1  clear ID/EX to NOP
- flush_W  out  1  clear MEM/WB to NOP
- mem_err  out  1  sticky memory timeout
- load_use_cnt  out  CNT_W  load-use stall events
- branch_flush_cnt  out  CNT_W  branch flush events
- mem_wait_cnt  out  CNT_W  cycles spent stalled on memory

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - FSM to RUN; timeout counter, all event counters and mem_err cleared.
  - While RST_N=0, combinational outputs are forced: all stall_*=0, flush_D=1, flush_E=1, flush_W=1.
- Hazard terms (combinational):
  - lu = memRead_E & (rd_E!=0) & ((use_rs1_D & rd_E==rs1_D) | (use_rs2_D & rd_E==rs2_D)).
  - mw = dmem_req_M & ~dmem_ack_M.
  - br = branchTaken_E.
- Priority, highest first: ERR, then mw, then br, then lu.
- Freeze (state ERR, or mw in RUN/MEM_WAIT):
  - stall_F=stall_D=stall_E=stall_M=1 and flush_W=1.
  - flush_D=flush_E=0.
  - br and lu are not acted on and not counted; both remain visible once the freeze releases, because the stages are held.
- Branch (no freeze, br=1): flush_D=1, flush_E=1, all stalls 0. A coincident lu is ignored because the dependent instruction is squashed.
- Load-use (no freeze, br=0, lu=1):
  - stall_F=1, stall_D=1, flush_E=1 for exactly one cycle.
  - The next cycle the load is in Memory and lu evaluates false.
- Otherwise all outputs are 0.
- All stall/flush outputs are same-cycle combinational; zero latency.
- FSM states:
  - RUN: mw goes to MEM_WAIT and loads the timeout counter with 1.
  - MEM_WAIT:
    - dmem_ack_M=1 returns to RUN; that cycle is not stalled.
    - Else, if the timeout counter equals MEM_TIMEOUT, go to ERR.
    - Else increment the timeout counter.
    - dmem_req_M dropping without ack also returns to RUN.
  - ERR: terminal until reset; mem_err=1 (registered, asserted the cycle after entry); full freeze held regardless of ack.
- Counters:
  - Each counter increments by 1 on a CLK edge when its event's output action is taken that cycle: lu acted on, br acted on, and each freeze cycle caused by mw (ERR cycles not counted).
  - Each counter saturates at 2^CNT_W-1 with no wrap.
  - Counters are registered, so their value updates the cycle after the event.
- Reset mid-operation (during MEM_WAIT or ERR): FSM returns to RUN next edge; mem_err and counters clear.

Test Plan:
- Load-use: memRead_E=1, rd_E=5, rs1_D=5, use_rs1_D=1 for 1 cycle -> stall_F=stall_D=flush_E=1 that cycle only; load_use_cnt 0->1. Repeat with rd_E=0 -> no stall, count unchanged.
- Branch over load-use: br=1 together with lu=1 -> flush_D=flush_E=1, stall_F=0; branch_flush_cnt+1, load_use_cnt unchanged.
- Memory wait: dmem_req_M=1, ack held low for 3 cycles, then ack=1:
  - 3 cycles with stall_F..stall_M=1 and flush_W=1, then release on the ack cycle.
  - mem_wait_cnt=3, FSM back in RUN.
  - Assert br=1 throughout -> flush only on the release cycle.
- Timeout: MEM_TIMEOUT=4, dmem_req_M=1, ack never -> ERR after 4 MEM_WAIT cycles; mem_err=1 next cycle; freeze persists after ack=1.
- Saturation: CNT_W=4, 20 branch events -> branch_flush_cnt=15.
- Reset mid-ERR: RST_N=0 for 1 edge -> mem_err=0, all counters 0, state RUN; flush_D/E/W=1 and stalls=0 while RST_N low.
